// File: rtl/psrv32_pkg.sv
// Shared definitions for the psrv32 pipeline hazard logic:
// FSM state encoding, forwarding selects, NOP constant and forwarding helper.
package psrv32_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_FAULT    = 2'd2
  } hz_state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // addi x0, x0, 0 -- what a flushed or bubbled pipeline register carries
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Youngest writer wins: MEM over WB; x0 is never forwarded.
  function automatic logic [1:0] fwd_select(
    input logic [4:0] rs,
    input logic [4:0] mem_rd,
    input logic       mem_we,
    input logic [4:0] wb_rd,
    input logic       wb_we
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (mem_we && (mem_rd != 5'd0) && (mem_rd == rs)) begin
      sel = FWD_MEM;
    end else if (wb_we && (wb_rd != 5'd0) && (wb_rd == rs)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_unit.sv
// EX-stage operand forwarding select generation (purely combinational).
module fwd_unit
  import psrv32_pkg::*;
(
  input  logic [4:0] ex_rs1_i,
  input  logic [4:0] ex_rs2_i,
  input  logic [4:0] mem_rd_i,
  input  logic       mem_reg_write_i,
  input  logic [4:0] wb_rd_i,
  input  logic       wb_reg_write_i,
  output logic [1:0] fwd_a_o,
  output logic [1:0] fwd_b_o
);

  // Per-operand select from the MEM and WB destination registers
  always_comb begin
    fwd_a_o = fwd_select(ex_rs1_i, mem_rd_i, mem_reg_write_i, wb_rd_i, wb_reg_write_i);
    fwd_b_o = fwd_select(ex_rs2_i, mem_rd_i, mem_reg_write_i, wb_rd_i, wb_reg_write_i);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Central hazard/stall controller for the 5-stage RV32 pipeline.
// Priority: memory freeze > EX redirect > load-use interlock.
// Optional macro HAZARD_PERF_CNT_EN enables the stall/flush perf counters;
// without it the counter ports are tied to zero.
module hazard_ctrl
  import psrv32_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 256
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [4:0]  id_rs1_i,
  input  logic [4:0]  id_rs2_i,
  input  logic        id_use_rs1_i,
  input  logic        id_use_rs2_i,
  input  logic [4:0]  ex_rd_i,
  input  logic        ex_mem_read_i,
  input  logic [4:0]  mem_rd_i,
  input  logic [4:0]  wb_rd_i,
  input  logic        mem_reg_write_i,
  input  logic        wb_reg_write_i,
  input  logic [4:0]  ex_rs1_i,
  input  logic [4:0]  ex_rs2_i,
  input  logic        ex_redirect_i,
  input  logic        mem_req_i,
  input  logic        mem_ready_i,
  output logic        pc_stall_o,
  output logic        if_id_stall_o,
  output logic        id_ex_stall_o,
  output logic        ex_mem_stall_o,
  output logic        if_id_flush_o,
  output logic        id_ex_flush_o,
  output logic        mem_wb_bubble_o,
  output logic [1:0]  fwd_a_o,
  output logic [1:0]  fwd_b_o,
  output logic        mem_err_o,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
);

  localparam int unsigned CW = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [CW-1:0] TIMEOUT_C  = CW'(MEM_TIMEOUT);
  localparam logic [CW-1:0] TIMEOUT_M1 = CW'(MEM_TIMEOUT - 1);

  hz_state_e     state_q, state_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;

  logic       freeze;
  logic       load_use;
  logic [1:0] fwd_a_raw, fwd_b_raw;

  fwd_unit u_fwd (
    .ex_rs1_i        (ex_rs1_i),
    .ex_rs2_i        (ex_rs2_i),
    .mem_rd_i        (mem_rd_i),
    .mem_reg_write_i (mem_reg_write_i),
    .wb_rd_i         (wb_rd_i),
    .wb_reg_write_i  (wb_reg_write_i),
    .fwd_a_o         (fwd_a_raw),
    .fwd_b_o         (fwd_b_raw)
  );

  // Hazard conditions derived straight from the stage inputs
  always_comb begin
    freeze   = mem_req_i & ~mem_ready_i;
    load_use = ex_mem_read_i && (ex_rd_i != 5'd0) &&
               ((id_use_rs1_i && (id_rs1_i == ex_rd_i)) ||
                (id_use_rs2_i && (id_rs2_i == ex_rd_i)));
  end

  // Memory-wait FSM and watchdog counter next-state
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      ST_RUN: begin
        if (freeze) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = CW'(1);
        end
      end
      ST_MEM_WAIT: begin
        if (!mem_req_i || mem_ready_i) begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q >= TIMEOUT_M1) begin
          // this cycle is the MEM_TIMEOUT-th consecutive not-ready cycle
          state_d    = ST_FAULT;
          wait_cnt_d = TIMEOUT_C;
        end else begin
          wait_cnt_d = wait_cnt_q + CW'(1);
        end
      end
      ST_FAULT: begin
        state_d    = ST_FAULT;
      end
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  // FSM state and wait counter registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Stall, flush, bubble, fault and forwarding outputs by priority
  always_comb begin
    pc_stall_o      = 1'b0;
    if_id_stall_o   = 1'b0;
    id_ex_stall_o   = 1'b0;
    ex_mem_stall_o  = 1'b0;
    if_id_flush_o   = 1'b0;
    id_ex_flush_o   = 1'b0;
    mem_wb_bubble_o = 1'b0;
    mem_err_o       = 1'b0;
    fwd_a_o         = FWD_RF;
    fwd_b_o         = FWD_RF;
    if (!reset_i) begin
      if_id_flush_o = 1'b1;
      id_ex_flush_o = 1'b1;
    end else begin
      fwd_a_o = fwd_a_raw;
      fwd_b_o = fwd_b_raw;
      if (state_q == ST_FAULT) begin
        pc_stall_o      = 1'b1;
        if_id_stall_o   = 1'b1;
        id_ex_stall_o   = 1'b1;
        ex_mem_stall_o  = 1'b1;
        mem_wb_bubble_o = 1'b1;
        mem_err_o       = 1'b1;
      end else if (freeze) begin
        pc_stall_o      = 1'b1;
        if_id_stall_o   = 1'b1;
        id_ex_stall_o   = 1'b1;
        ex_mem_stall_o  = 1'b1;
        mem_wb_bubble_o = 1'b1;
      end else if (ex_redirect_i) begin
        if_id_flush_o = 1'b1;
        id_ex_flush_o = 1'b1;
      end else if (load_use) begin
        pc_stall_o    = 1'b1;
        if_id_stall_o = 1'b1;
        id_ex_flush_o = 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Free-running stall/flush event counters, wrapping modulo 2^32
  always_comb begin
    stall_cnt_d = stall_cnt_q + {31'd0, pc_stall_o};
    flush_cnt_d = flush_cnt_q + {31'd0, if_id_flush_o};
  end

  // Counter registers; reset wins over the flush asserted during reset
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = reset_i ? stall_cnt_q : '0;
  assign flush_cnt_o = reset_i ? flush_cnt_q : '0;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (MEM_TIMEOUT = 4).
module tb_hazard_ctrl;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [4:0]  id_rs1_i, id_rs2_i, ex_rd_i, mem_rd_i, wb_rd_i, ex_rs1_i, ex_rs2_i;
  logic        id_use_rs1_i, id_use_rs2_i, ex_mem_read_i;
  logic        mem_reg_write_i, wb_reg_write_i, ex_redirect_i, mem_req_i, mem_ready_i;
  logic        pc_stall_o, if_id_stall_o, id_ex_stall_o, ex_mem_stall_o;
  logic        if_id_flush_o, id_ex_flush_o, mem_wb_bubble_o, mem_err_o;
  logic [1:0]  fwd_a_o, fwd_b_o;
  logic [31:0] stall_cnt_o, flush_cnt_o;

  int total = 0;
  int bad   = 0;
  int unsigned exp_stall = 0;
  int unsigned exp_flush = 0;

  always #5 clk_i = ~clk_i;

  hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
    .id_use_rs1_i(id_use_rs1_i), .id_use_rs2_i(id_use_rs2_i),
    .ex_rd_i(ex_rd_i), .ex_mem_read_i(ex_mem_read_i),
    .mem_rd_i(mem_rd_i), .wb_rd_i(wb_rd_i),
    .mem_reg_write_i(mem_reg_write_i), .wb_reg_write_i(wb_reg_write_i),
    .ex_rs1_i(ex_rs1_i), .ex_rs2_i(ex_rs2_i),
    .ex_redirect_i(ex_redirect_i), .mem_req_i(mem_req_i), .mem_ready_i(mem_ready_i),
    .pc_stall_o(pc_stall_o), .if_id_stall_o(if_id_stall_o),
    .id_ex_stall_o(id_ex_stall_o), .ex_mem_stall_o(ex_mem_stall_o),
    .if_id_flush_o(if_id_flush_o), .id_ex_flush_o(id_ex_flush_o),
    .mem_wb_bubble_o(mem_wb_bubble_o), .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o),
    .mem_err_o(mem_err_o), .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  task automatic idle();
    id_rs1_i = '0; id_rs2_i = '0; id_use_rs1_i = 0; id_use_rs2_i = 0;
    ex_rd_i = '0; ex_mem_read_i = 0; mem_rd_i = '0; wb_rd_i = '0;
    mem_reg_write_i = 0; wb_reg_write_i = 0; ex_rs1_i = '0; ex_rs2_i = '0;
    ex_redirect_i = 0; mem_req_i = 0; mem_ready_i = 0;
  endtask

  // Advance one clock, accounting the expected perf-counter events of this cycle
  task automatic step(input logic s, input logic f);
`ifdef HAZARD_PERF_CNT_EN
    if (s) exp_stall++;
    if (f) exp_flush++;
`endif
    @(posedge clk_i); #1;
  endtask

  task automatic test_reset();
    idle();
    reset_i = 0; mem_req_i = 1; ex_redirect_i = 1;
    mem_rd_i = 5'd7; mem_reg_write_i = 1; ex_rs1_i = 5'd7;
    @(posedge clk_i); #1;
    total++; if (if_id_flush_o !== 1'b1) begin bad++; $display("FAIL rst_if_id_flush got=%0b exp=1", if_id_flush_o); end
    total++; if (id_ex_flush_o !== 1'b1) begin bad++; $display("FAIL rst_id_ex_flush got=%0b exp=1", id_ex_flush_o); end
    total++; if ({pc_stall_o, if_id_stall_o, id_ex_stall_o, ex_mem_stall_o, mem_wb_bubble_o} !== 5'b0)
      begin bad++; $display("FAIL rst_stalls got=%b exp=00000", {pc_stall_o, if_id_stall_o, id_ex_stall_o, ex_mem_stall_o, mem_wb_bubble_o}); end
    total++; if (fwd_a_o !== 2'b00) begin bad++; $display("FAIL rst_fwd_a got=%b exp=00", fwd_a_o); end
    total++; if (mem_err_o !== 1'b0) begin bad++; $display("FAIL rst_mem_err got=%0b exp=0", mem_err_o); end
    total++; if (stall_cnt_o !== 32'd0 || flush_cnt_o !== 32'd0)
      begin bad++; $display("FAIL rst_cnts got=%0d/%0d exp=0/0", stall_cnt_o, flush_cnt_o); end
    exp_stall = 0; exp_flush = 0;
    idle();
    reset_i = 1;
    #1;
    total++; if (pc_stall_o !== 1'b0 || if_id_flush_o !== 1'b0)
      begin bad++; $display("FAIL post_rst_idle got=%0b%0b exp=00", pc_stall_o, if_id_flush_o); end
  endtask

  task automatic test_load_use();
    idle();
    ex_mem_read_i = 1; ex_rd_i = 5'd5; id_rs1_i = 5'd5; id_use_rs1_i = 1; #1;
    total++; if ({pc_stall_o, if_id_stall_o, id_ex_flush_o} !== 3'b111)
      begin bad++; $display("FAIL lu_rs1 got=%b exp=111", {pc_stall_o, if_id_stall_o, id_ex_flush_o}); end
    total++; if ({if_id_flush_o, id_ex_stall_o, ex_mem_stall_o, mem_wb_bubble_o} !== 4'b0)
      begin bad++; $display("FAIL lu_rs1_other got=%b exp=0000", {if_id_flush_o, id_ex_stall_o, ex_mem_stall_o, mem_wb_bubble_o}); end
    step(1, 0);
    ex_rd_i = 5'd0; id_rs1_i = 5'd0; #1;
    total++; if ({pc_stall_o, id_ex_flush_o} !== 2'b00)
      begin bad++; $display("FAIL lu_rd0 got=%b exp=00", {pc_stall_o, id_ex_flush_o}); end
    step(0, 0);
    ex_rd_i = 5'd9; id_rs1_i = 5'd3; id_use_rs1_i = 1; id_rs2_i = 5'd9; id_use_rs2_i = 1; #1;
    total++; if (pc_stall_o !== 1'b1) begin bad++; $display("FAIL lu_rs2 got=%0b exp=1", pc_stall_o); end
    step(1, 0);
    id_use_rs2_i = 0; id_rs1_i = 5'd9; id_use_rs1_i = 0; #1;
    total++; if (pc_stall_o !== 1'b0) begin bad++; $display("FAIL lu_unused got=%0b exp=0", pc_stall_o); end
    id_use_rs1_i = 1; ex_mem_read_i = 0; #1;
    total++; if (pc_stall_o !== 1'b0) begin bad++; $display("FAIL lu_noload got=%0b exp=0", pc_stall_o); end
    step(0, 0);
  endtask

  task automatic test_redirect();
    idle();
    ex_mem_read_i = 1; ex_rd_i = 5'd5; id_rs1_i = 5'd5; id_use_rs1_i = 1; ex_redirect_i = 1; #1;
    total++; if ({if_id_flush_o, id_ex_flush_o} !== 2'b11)
      begin bad++; $display("FAIL rd_flush got=%b exp=11", {if_id_flush_o, id_ex_flush_o}); end
    total++; if ({pc_stall_o, if_id_stall_o} !== 2'b00)
      begin bad++; $display("FAIL rd_nostall got=%b exp=00", {pc_stall_o, if_id_stall_o}); end
    step(0, 1);
    total++; if (flush_cnt_o !== 32'(exp_flush))
      begin bad++; $display("FAIL rd_flush_cnt got=%0d exp=%0d", flush_cnt_o, exp_flush); end
    total++; if (stall_cnt_o !== 32'(exp_stall))
      begin bad++; $display("FAIL rd_stall_cnt got=%0d exp=%0d", stall_cnt_o, exp_stall); end
  endtask

  task automatic test_mem_wait();
    idle();
    mem_req_i = 1; ex_redirect_i = 1;
    mem_rd_i = 5'd7; mem_reg_write_i = 1; ex_rs1_i = 5'd7;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if ({pc_stall_o, if_id_stall_o, id_ex_stall_o, ex_mem_stall_o, mem_wb_bubble_o} !== 5'b11111)
        begin bad++; $display("FAIL mw_freeze%0d got=%b exp=11111", i, {pc_stall_o, if_id_stall_o, id_ex_stall_o, ex_mem_stall_o, mem_wb_bubble_o}); end
      total++; if ({if_id_flush_o, id_ex_flush_o, mem_err_o} !== 3'b000)
        begin bad++; $display("FAIL mw_noflush%0d got=%b exp=000", i, {if_id_flush_o, id_ex_flush_o, mem_err_o}); end
      total++; if (fwd_a_o !== 2'b10) begin bad++; $display("FAIL mw_fwd%0d got=%b exp=10", i, fwd_a_o); end
      step(1, 0);
    end
    mem_ready_i = 1; #1;
    total++; if ({pc_stall_o, mem_wb_bubble_o} !== 2'b00)
      begin bad++; $display("FAIL mw_release got=%b exp=00", {pc_stall_o, mem_wb_bubble_o}); end
    total++; if ({if_id_flush_o, id_ex_flush_o} !== 2'b11)
      begin bad++; $display("FAIL mw_redirect got=%b exp=11", {if_id_flush_o, id_ex_flush_o}); end
    step(0, 1);
    idle(); #1;
    total++; if ({pc_stall_o, mem_err_o} !== 2'b00)
      begin bad++; $display("FAIL mw_run got=%b exp=00", {pc_stall_o, mem_err_o}); end
    step(0, 0);
  endtask

  task automatic test_mem_drop();
    idle();
    mem_req_i = 1;
    step(1, 0); step(1, 0);
    mem_req_i = 0; #1;
    total++; if (pc_stall_o !== 1'b0) begin bad++; $display("FAIL md_drop got=%0b exp=0", pc_stall_o); end
    step(0, 0);
    mem_req_i = 1;
    for (int i = 0; i < 3; i++) step(1, 0);
    #1;
    total++; if (mem_err_o !== 1'b0) begin bad++; $display("FAIL md_no_fault got=%0b exp=0", mem_err_o); end
    mem_ready_i = 1; #1;
    total++; if (pc_stall_o !== 1'b0) begin bad++; $display("FAIL md_ready got=%0b exp=0", pc_stall_o); end
    step(0, 0);
    idle();
  endtask

  task automatic test_forwarding();
    idle();
    mem_rd_i = 5'd7; wb_rd_i = 5'd7; mem_reg_write_i = 1; wb_reg_write_i = 1;
    ex_rs1_i = 5'd7; ex_rs2_i = 5'd0; #1;
    total++; if (fwd_a_o !== 2'b10) begin bad++; $display("FAIL fw_mem got=%b exp=10", fwd_a_o); end
    total++; if (fwd_b_o !== 2'b00) begin bad++; $display("FAIL fw_rs0 got=%b exp=00", fwd_b_o); end
    mem_reg_write_i = 0; ex_rs2_i = 5'd7; #1;
    total++; if (fwd_a_o !== 2'b01) begin bad++; $display("FAIL fw_wb got=%b exp=01", fwd_a_o); end
    total++; if (fwd_b_o !== 2'b01) begin bad++; $display("FAIL fw_wb_b got=%b exp=01", fwd_b_o); end
    mem_rd_i = 5'd0; wb_rd_i = 5'd0; mem_reg_write_i = 1; ex_rs1_i = 5'd0; ex_rs2_i = 5'd0; #1;
    total++; if ({fwd_a_o, fwd_b_o} !== 4'b0000)
      begin bad++; $display("FAIL fw_x0 got=%b exp=0000", {fwd_a_o, fwd_b_o}); end
    mem_rd_i = 5'd3; wb_rd_i = 5'd4; ex_rs1_i = 5'd3; ex_rs2_i = 5'd4; #1;
    total++; if ({fwd_a_o, fwd_b_o} !== 4'b1001)
      begin bad++; $display("FAIL fw_split got=%b exp=1001", {fwd_a_o, fwd_b_o}); end
    wb_reg_write_i = 0; #1;
    total++; if (fwd_b_o !== 2'b00) begin bad++; $display("FAIL fw_wb_off got=%b exp=00", fwd_b_o); end
    step(0, 0);
    idle();
  endtask

  task automatic test_timeout();
    idle();
    mem_req_i = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if ({mem_err_o, pc_stall_o} !== 2'b01)
        begin bad++; $display("FAIL to_wait%0d got=%b exp=01", i, {mem_err_o, pc_stall_o}); end
      step(1, 0);
    end
    total++; if (mem_err_o !== 1'b1) begin bad++; $display("FAIL to_fault got=%0b exp=1", mem_err_o); end
    mem_req_i = 0; ex_redirect_i = 1; #1;
    total++; if ({pc_stall_o, if_id_stall_o, id_ex_stall_o, ex_mem_stall_o} !== 4'b1111)
      begin bad++; $display("FAIL to_stalls got=%b exp=1111", {pc_stall_o, if_id_stall_o, id_ex_stall_o, ex_mem_stall_o}); end
    total++; if ({if_id_flush_o, id_ex_flush_o, mem_err_o} !== 3'b001)
      begin bad++; $display("FAIL to_sticky got=%b exp=001", {if_id_flush_o, id_ex_flush_o, mem_err_o}); end
    step(1, 0);
    total++; if (stall_cnt_o !== 32'(exp_stall))
      begin bad++; $display("FAIL to_stall_cnt got=%0d exp=%0d", stall_cnt_o, exp_stall); end
    reset_i = 0; #1;
    total++; if ({if_id_flush_o, id_ex_flush_o, pc_stall_o, mem_err_o} !== 4'b1100)
      begin bad++; $display("FAIL to_rst got=%b exp=1100", {if_id_flush_o, id_ex_flush_o, pc_stall_o, mem_err_o}); end
    @(posedge clk_i); #1;
    exp_stall = 0; exp_flush = 0;
    reset_i = 1; idle(); #1;
    total++; if ({mem_err_o, pc_stall_o} !== 2'b00)
      begin bad++; $display("FAIL to_recover got=%b exp=00", {mem_err_o, pc_stall_o}); end
    total++; if (stall_cnt_o !== 32'd0 || flush_cnt_o !== 32'd0)
      begin bad++; $display("FAIL to_cnt_clr got=%0d/%0d exp=0/0", stall_cnt_o, flush_cnt_o); end
  endtask

  task automatic test_back_to_back();
    idle();
    ex_mem_read_i = 1; ex_rd_i = 5'd6; id_rs2_i = 5'd6; id_use_rs2_i = 1;
    step(1, 0);
    ex_redirect_i = 1;
    step(0, 1);
    mem_req_i = 1; #1;
    total++; if ({pc_stall_o, if_id_flush_o} !== 2'b10)
      begin bad++; $display("FAIL b2b_freeze got=%b exp=10", {pc_stall_o, if_id_flush_o}); end
    step(1, 0);
    total++; if (stall_cnt_o !== 32'(exp_stall) || flush_cnt_o !== 32'(exp_flush))
      begin bad++; $display("FAIL b2b_cnts got=%0d/%0d exp=%0d/%0d", stall_cnt_o, flush_cnt_o, exp_stall, exp_flush); end
    idle(); mem_ready_i = 1; mem_req_i = 1;
    step(0, 0);
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    reset_i = 0;
    test_reset();
    test_load_use();
    test_redirect();
    test_mem_wait();
    test_mem_drop();
    test_forwarding();
    test_timeout();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Central hazard and stall controller for the 5-stage RV32 pipeline, instantiated in `cpu` next to the stage pipeline registers. It produces the per-stage stall, flush and bubble controls and the EX-stage operand forwarding selects. It handles load-use interlocks, taken branches and jumps resolved in EX, and multi-cycle data-memory waits, including a timeout watchdog.

## Interface
- `MEM_TIMEOUT`, 256: maximum consecutive data-memory wait cycles before a fault is declared (must be ≥2).
- `clk_i`  in  1  single clock, rising edge.
- `reset_i`  in  1  synchronous, active-low reset.
- `id_rs1_i`, `id_rs2_i`  in  5 each  source registers of the instruction in ID.
- `id_use_rs1_i`, `id_use_rs2_i`  in  1 each  the ID instruction actually reads rs1 / rs2.
- `ex_rd_i`  in  5  destination register in EX.
- `ex_mem_read_i`  in  1  EX instruction is a load.
- `mem_rd_i`, `wb_rd_i`  in  5 each  destination registers in MEM / WB.
- `mem_reg_write_i`, `wb_reg_write_i`  in  1 each  MEM / WB instruction writes the register file.
- `ex_rs1_i`, `ex_rs2_i`  in  5 each  source registers of the instruction in EX (for forwarding).
- `ex_redirect_i`  in  1  branch taken or jump in EX (`isbranchtaken | jump`).
- `mem_req_i`  in  1  MEM stage is issuing a data-memory read or write.
- `mem_ready_i`  in  1  data memory completes the access this cycle.
- `pc_stall_o`, `if_id_stall_o`, `id_ex_stall_o`, `ex_mem_stall_o`  out  1 each  hold that register.
- `if_id_flush_o`, `id_ex_flush_o`  out  1 each  load a NOP into that register.
- `mem_wb_bubble_o`  out  1  load a NOP into MEM/WB.
- `fwd_a_o`, `fwd_b_o`  out  2 each  EX operand select: 00 = register file, 01 = WB result, 10 = MEM ALU result.
- `mem_err_o`  out  1  sticky memory-timeout fault.
- `stall_cnt_o`, `flush_cnt_o`  out  32 each  performance counters (see Configuration).

## Operation
- FSM states are RUN, MEM_WAIT and FAULT. The wait counter has width `$clog2(MEM_TIMEOUT)+1`.
- **Reset values.** While `reset_i` is 0:
  - outputs: `if_id_flush_o`=1 and `id_ex_flush_o`=1; all other outputs 0.
  - registered state: FSM = RUN, wait counter = 0, `mem_err_o`=0, both perf counters = 0.
- **Memory freeze.**
  - Condition: `freeze = mem_req_i & ~mem_ready_i`. This is combinational and applies in both RUN and MEM_WAIT.
  - Action: assert all four stall outputs and `mem_wb_bubble_o`. Suppress every flush and the load-use logic.
- **Branch flush.**
  - Condition: no freeze and `ex_redirect_i`=1.
  - Action: `if_id_flush_o`=1 and `id_ex_flush_o`=1. No stalls. The load-use interlock is suppressed, because the ID instruction is discarded.
- **Load-use interlock.**
  - Condition: no freeze, no redirect, `ex_mem_read_i`, `ex_rd_i`≠0, and (`id_use_rs1_i` & rs1 match, or `id_use_rs2_i` & rs2 match).
  - Action: `pc_stall_o`=1, `if_id_stall_o`=1, `id_ex_flush_o`=1, for exactly one cycle per occurrence.
- **Priority:** freeze > redirect > load-use. A redirect held during a freeze takes effect in the first unfrozen cycle.
- **FSM transitions.**
  - RUN→MEM_WAIT when freeze; the counter is set to 1.
  - In MEM_WAIT, `mem_ready_i` returns to RUN and clears the counter. Otherwise the counter increments.
  - The counter reaching `MEM_TIMEOUT` with the access still not ready moves to FAULT.
  - If `mem_req_i` drops in MEM_WAIT, return to RUN and clear the counter.
- **FAULT.** `mem_err_o`=1 and all stalls are asserted; no flushes. The block stays in FAULT until reset.
- **Forwarding**, per operand:
  - select 10 if `mem_reg_write_i`, `mem_rd_i`≠0 and `mem_rd_i`==`ex_rsN_i`;
  - else 01 if the same holds for WB;
  - else 00.
  - Register x0 is never forwarded. Forwarding selects stay valid during a freeze.

## Timing
- Stall, flush and forward outputs are combinational from the inputs and the current state. There is no added latency, so they act at the next clock edge.
- The load-use interlock inserts exactly 1 bubble. On the following cycle the load is in MEM and forwarding (01 from WB one cycle later) covers the dependency.
- A wait of N cycles (mem_ready rising on cycle N+1) produces N freeze cycles and no extra bubble after `mem_ready_i`.
- The fault is declared on the edge after `MEM_TIMEOUT` consecutive not-ready cycles.
- Reset taken mid-MEM_WAIT or in FAULT returns to RUN on the next edge with `mem_err_o`=0.

## Configuration
- `HAZARD_PERF_CNT_EN` defined:
  - `stall_cnt_o` increments on every cycle `pc_stall_o`=1.
  - `flush_cnt_o` increments on every cycle `if_id_flush_o`=1 outside reset.
  - Both are 32-bit, wrap modulo 2^32 and clear on reset.
- Undefined: the ports remain present, tied to 0, with no counter flops.

## Structure
- Shared package `psrv32_pkg` holds:
  - FSM state encoding (RUN=0, MEM_WAIT=1, FAULT=2);
  - forwarding select constants (`FWD_RF`, `FWD_WB`, `FWD_MEM`);
  - the NOP instruction constant used by the flush and bubble paths.
- One natural sub-module: `fwd_unit`, purely combinational, producing `fwd_a_o`/`fwd_b_o`. The FSM, interlock and counters stay in `hazard_ctrl`.

## Test plan
- **Load-use:** `ex_mem_read_i`=1, `ex_rd_i`=5, `id_rs1_i`=5, `id_use_rs1_i`=1 → one cycle of `pc_stall_o`=`if_id_stall_o`=`id_ex_flush_o`=1. With rd=0 instead → no stall.
- **Redirect with simultaneous load-use:** `ex_redirect_i`=1 → `if_id_flush_o`=`id_ex_flush_o`=1, no stall. With `HAZARD_PERF_CNT_EN`, `flush_cnt_o`=1.
- **Memory wait:** `mem_req_i`=1 with `mem_ready_i` low for 3 cycles → 3 freeze cycles with `mem_wb_bubble_o`=1, then RUN. A redirect held throughout flushes on the 4th cycle.
- **Timeout:** `MEM_TIMEOUT`=4, ready never asserted → `mem_err_o`=1 after 4 wait cycles, stalls held. `reset_i`=0 for one cycle → RUN, `mem_err_o`=0.
- **Forwarding:** `mem_rd_i`=`wb_rd_i`=7, both writing, `ex_rs1_i`=7 → `fwd_a_o`=10. MEM not writing → 01. `ex_rs2_i`=0 → `fwd_b_o`=00.
